branch_resolve_buffer: RTL and testbench
========================================

Name: branch_resolve_buffer

Overview:
In-order buffer between fetch and the two-bit branch predictor's update path. It records each predicted branch at fetch: PC, prediction bit and taken-target. When execute resolves the oldest branch, the buffer produces the predictor update (PC, actual outcome) and a mispredict redirect. On mispredict it flushes all younger in-flight entries so the front end restarts cleanly.

Parameters:
DEPTH, 4, number of in-flight branch entries; power of two, >= 2
PC_W, 32, PC and target width
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  fetch presents a predicted branch
alloc_ready  out  1  buffer can accept an entry (not full)
alloc_pc  in  PC_W  branch PC
alloc_pred  in  1  predictor output for this branch (1 = taken)
alloc_target  in  PC_W  taken target
resolve_valid  in  1  execute resolves the oldest branch
resolve_taken  in  1  actual outcome
upd_valid  out  1  predictor update strobe
upd_pc  out  PC_W  PC to update (predictor indexes [3:0])
upd_outcome  out  1  actual outcome to predictor
mispredict  out  1  redirect strobe
redirect_pc  out  PC_W  correct next PC
count  out  CNT_W  current occupancy
stray_resolve  out  1  resolve arrived while empty
stat_resolved  out  16  resolved-branch count (see optional feature)
stat_mispred  out  16  mispredict count (see optional feature)

Behaviour:
- Reset (async, rst_n=0): head/tail pointers=0, count=0, all registered outputs 0 (upd_valid, upd_pc, upd_outcome, mispredict, redirect_pc, stray_resolve, stats). Entry storage is not reset.
- alloc_ready = (count != DEPTH), combinational from count only. No same-cycle bypass: full + resolve still gives ready=0.
- Alloc fires when alloc_valid && alloc_ready. Writes {pc, pred, target} at tail; tail wraps modulo DEPTH.
- Resolve fires when resolve_valid && count != 0 and always pops the head.
- Outputs are registered, one cycle after resolve fires:
  - upd_valid=1; upd_pc=head.pc; upd_outcome=resolve_taken.
  - mispredict=1 iff resolve_taken != head.pred.
  - redirect_pc = resolve_taken ? head.target : head.pc + 4, truncated to PC_W. It is valid only while mispredict=1 and holds its last value otherwise.
  - All strobes are single-cycle pulses.
- Mispredict flush, same edge as the pop: tail=head+1, count=0. Any alloc in the same cycle is discarded and not counted.
- Resolve while count==0: ignored, no update. stray_resolve pulses one cycle.
- Simultaneous alloc + correct resolve: count unchanged, both pointers advance.
- Reset mid-operation: all in-flight entries dropped; no update is emitted for them.
- count never exceeds DEPTH and never underflows.

Optional Feature:
BRB_STATS_EN
- Defined: stat_resolved increments per fired resolve; stat_mispred increments per mispredict. Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both ports tied to 0 and no counter flops.

Decomposition:
- Shared package branch_pkg:
  - brb_entry_t struct {pc, pred, target}
  - PC_INC = 4
  - BHT_IDX_W = 4
  - BEQ_OPCODE = 6'b000100
- One sub-module brb_ptr_ctrl: head/tail/count, full/empty, push/pop/flush. The top holds storage and the resolve/redirect logic.

Test Plan:
- Reset, alloc pc=0x10 pred=1 target=0x40, resolve taken=1 -> next cycle upd_valid=1, upd_pc=0x10, upd_outcome=1, mispredict=0, count=0.
- Alloc pc=0x20 pred=1 target=0x80, resolve taken=0 -> mispredict=1, redirect_pc=0x24, upd_outcome=0.
- Fill 4 entries (pc 0x0,0x4,0x8,0xC, pred=0) -> alloc_ready=0 and count=4. Then resolve on entry 0x0 with taken=1 -> redirect_pc=entry0.target, count=0, entries 0x4–0xC never updated.
- Resolve with count=0 -> stray_resolve pulse, upd_valid stays 0.
- Full plus continuous alloc+correct resolve for 10 cycles -> pointers wrap, upd_pc order matches alloc order, count stable.
- Assert rst_n=0 mid-stream with 3 entries -> count=0 immediately and no upd_valid after release. With BRB_STATS_EN, after 5 resolves including 2 mispredicts -> stat_resolved=5, stat_mispred=2.

Source files
------------

// File: rtl/branch_resolve_buffer_pkg.sv
// Shared types and constants for the branch resolve buffer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package branch_pkg;

  localparam int          BRB_PC_W   = 32;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam int          BHT_IDX_W  = 4;
  localparam logic [5:0]  BEQ_OPCODE = 6'b000100;

  // One in-flight predicted branch as recorded at fetch.
  typedef struct packed {
    logic [BRB_PC_W-1:0] pc;
    logic                pred;
    logic [BRB_PC_W-1:0] target;
  } brb_entry_t;

endpackage

// File: rtl/branch_resolve_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the branch resolve buffer ring.
// Latency: pointer and count updates land on the clock edge after push/pop/flush.
// Backpressure: full is derived from count alone; the caller gates push with it.
module brb_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Flush discards every younger entry: both pointers land just past the popped head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= head + 1'b1;
      tail  <= head + 1'b1;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_buffer.sv
// In-order buffer of predicted branches; emits predictor update and mispredict redirect.
// Latency: update/redirect outputs register one cycle after the resolve fires.
// Backpressure: alloc_ready drops when full (no same-cycle bypass); optional stats via BRB_STATS_EN.
module branch_resolve_buffer
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [PC_W-1:0]  alloc_pc,
  input  logic             alloc_pred,
  input  logic [PC_W-1:0]  alloc_target,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_outcome,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] count,
  output logic             stray_resolve,
  output logic [15:0]      stat_resolved,
  output logic [15:0]      stat_mispred
);

  localparam int PTR_W = $clog2(DEPTH);

  brb_entry_t       mem [DEPTH];
  brb_entry_t       head_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wrong;
  logic             flush;
  logic             push;

  assign head_e      = mem[head];
  assign pop         = resolve_valid && !empty;
  assign wrong       = (resolve_taken != head_e.pred);
  assign flush       = pop && wrong;
  // An alloc racing a mispredict belongs to the wrong path and is dropped.
  assign push        = alloc_valid && !full && !flush;
  assign alloc_ready = !full;

  brb_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Entry storage is write-only at tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{pc: BRB_PC_W'(alloc_pc), pred: alloc_pred, target: BRB_PC_W'(alloc_target)};
    end
  end

  // Registered update/redirect strobes; payloads hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid     <= 1'b0;
      upd_pc        <= '0;
      upd_outcome   <= 1'b0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      stray_resolve <= 1'b0;
    end else begin
      upd_valid     <= pop;
      mispredict    <= flush;
      stray_resolve <= resolve_valid && empty;
      if (pop) begin
        upd_pc      <= PC_W'(head_e.pc);
        upd_outcome <= resolve_taken;
      end
      if (flush) begin
        redirect_pc <= resolve_taken ? PC_W'(head_e.target) : PC_W'(head_e.pc + PC_INC);
      end
    end
  end

`ifdef BRB_STATS_EN
  // Saturating resolve / mispredict counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && stat_resolved != 16'hFFFF)  stat_resolved <= stat_resolved + 16'd1;
      if (flush && stat_mispred != 16'hFFFF) stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_buffer.sv
// Randomized plus directed bench for branch_resolve_buffer against a queue-based model.
// Latency: model predicts registered outputs one cycle after each driven input set.
// Backpressure: model tracks occupancy and mirrors the expected alloc_ready.
module tb_branch_resolve_buffer;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_valid = 1'b0;
  logic             alloc_ready;
  logic [PC_W-1:0]  alloc_pc = '0;
  logic             alloc_pred = 1'b0;
  logic [PC_W-1:0]  alloc_target = '0;
  logic             resolve_valid = 1'b0;
  logic             resolve_taken = 1'b0;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_outcome;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] count;
  logic             stray_resolve;
  logic [15:0]      stat_resolved;
  logic [15:0]      stat_mispred;

  always #5 clk = ~clk;

  branch_resolve_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_pred(alloc_pred), .alloc_target(alloc_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_outcome(upd_outcome),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count),
    .stray_resolve(stray_resolve), .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } ent_t;

  // Behavioural model: a plain queue of in-flight branches plus expected outputs.
  ent_t        q[$];
  logic        m_upd_valid, m_upd_outcome, m_mis, m_stray;
  logic [31:0] m_upd_pc, m_redirect;
  int          m_res, m_mis_n;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_upd_valid = 0; m_upd_outcome = 0; m_mis = 0; m_stray = 0;
    m_upd_pc = 0; m_redirect = 0; m_res = 0; m_mis_n = 0;
  endtask

  // Applies the rules to the input set present at this clock edge.
  task automatic model_edge();
    ent_t e;
    bit   fire_a, fire_r, bad;
    fire_a = alloc_valid && (q.size() != DEPTH);
    fire_r = resolve_valid && (q.size() != 0);
    m_stray = resolve_valid && (q.size() == 0);
    m_upd_valid = fire_r;
    m_mis = 0;
    bad = 0;
    if (fire_r) begin
      e = q.pop_front();
      m_upd_pc = e.pc;
      m_upd_outcome = resolve_taken;
      bad = (resolve_taken != e.pred);
      m_mis = bad;
      if (m_res < 65535) m_res++;
      if (bad) begin
        m_redirect = resolve_taken ? e.target : e.pc + 32'd4;
        if (m_mis_n < 65535) m_mis_n++;
        q.delete();
      end
    end
    if (fire_a && !bad) q.push_back('{alloc_pc, alloc_pred, alloc_target});
  endtask

  task automatic compare_all();
    chk("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
    chk("mispredict", 32'(mispredict), 32'(m_mis));
    chk("stray_resolve", 32'(stray_resolve), 32'(m_stray));
    chk("count", 32'(count), q.size());
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() != DEPTH));
    if (m_upd_valid) begin
      chk("upd_pc", upd_pc, m_upd_pc);
      chk("upd_outcome", 32'(upd_outcome), 32'(m_upd_outcome));
    end
    if (m_mis) chk("redirect_pc", redirect_pc, m_redirect);
`ifdef BRB_STATS_EN
    chk("stat_resolved", 32'(stat_resolved), m_res);
    chk("stat_mispred", 32'(stat_mispred), m_mis_n);
`else
    chk("stat_resolved", 32'(stat_resolved), 0);
    chk("stat_mispred", 32'(stat_mispred), 0);
`endif
  endtask

  // Drive one cycle of inputs (from just after a falling edge), advance, then compare.
  task automatic step(input logic av, input logic [31:0] apc, input logic ap,
                      input logic [31:0] at, input logic rv, input logic rt);
    alloc_valid = av; alloc_pc = apc; alloc_pred = ap; alloc_target = at;
    resolve_valid = rv; resolve_taken = rt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    alloc_valid = 0; resolve_valid = 0;
    model_reset();
    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_upd_valid", 32'(upd_valid), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    rst_n = 0;
    #12;
    compare_all();
    chk("reset_upd_pc", upd_pc, 0);
    chk("reset_redirect", redirect_pc, 0);
    @(negedge clk);
    rst_n = 1;

    // Correct prediction: update, no redirect.
    step(1, 32'h10, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("t1_upd_valid", 32'(upd_valid), 1);
    chk("t1_upd_pc", upd_pc, 32'h10);
    chk("t1_outcome", 32'(upd_outcome), 1);
    chk("t1_mis", 32'(mispredict), 0);
    chk("t1_count", 32'(count), 0);

    // Predicted taken, actually not taken: redirect to fall-through.
    step(1, 32'h20, 1, 32'h80, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_mis", 32'(mispredict), 1);
    chk("t2_redirect", redirect_pc, 32'h24);
    chk("t2_outcome", 32'(upd_outcome), 0);

    // Fill, then mispredict on the oldest flushes the rest.
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), 0, 32'h100 + 32'(i), 0, 0);
    chk("t3_ready", 32'(alloc_ready), 0);
    chk("t3_count", 32'(count), 4);
    step(1, 32'h77, 0, 32'h99, 1, 1);
    chk("t3_redirect", redirect_pc, 32'h100);
    chk("t3_count_after", 32'(count), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("t3_no_update", 32'(upd_valid), 0);
    end

    // Resolve while empty.
    step(0, 0, 0, 0, 1, 1);
    chk("t4_stray", 32'(stray_resolve), 1);
    chk("t4_upd_valid", 32'(upd_valid), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_stray_pulse", 32'(stray_resolve), 0);

    // Full plus continuous alloc with correct resolves: wrap, order kept.
    for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(4 * i), 1, 32'h0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h300 + 32'(4 * i), 1, 32'h0, 1, 1);
    chk("t5_count_stable", 32'(count), 3);

    // Reset with entries in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(4 * i), 0, 32'h0, 0, 0);
    do_reset();
    chk("t6_count_after", 32'(count), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t6_stray_after", 32'(stray_resolve), 1);

    // Five resolves, two mispredicted.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h500 + 32'(4 * i), 1, 32'h600, 0, 0);
      step(0, 0, 0, 0, 1, (i == 1 || i == 3) ? 1'b0 : 1'b1);
    end
`ifdef BRB_STATS_EN
    chk("t7_stat_res", 32'(stat_resolved), 5);
    chk("t7_stat_mis", 32'(stat_mispred), 2);
`else
    chk("t7_stat_res", 32'(stat_resolved), 0);
    chk("t7_stat_mis", 32'(stat_mispred), 0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic av, ap, rv, rt;
      av = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 45);
      ap = 1'($urandom);
      rt = ($urandom_range(0, 99) < 75) ? (q.size() != 0 ? q[0].pred : 1'b0) : 1'($urandom);
      step(av, {$urandom} & 32'hFFFF_FFFC, ap, $urandom, rv, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
